// File: rtl/fifo_uart_tx.sv
//-----------------------------------------------------------------------------
// fifo_uart_tx
// Pulls words from a first-word-fall-through FIFO and sends each as an 8N1
// style serial frame: start bit (0), DAT_WIDTH data bits LSB first, optional
// even parity bit, stop bit (1). Every bit lasts CLKS_PER_BIT clk cycles.
// A word waiting at the end of a stop bit starts the next frame with no gap.
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even parity
// bit between the last data bit and the stop bit.
//
// Parameters
//   DAT_WIDTH     data word width in bits
//   CLKS_PER_BIT  clk cycles per serial bit (2 or more)
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   i_fifo_empty  source FIFO empty flag
//   i_fifo_data   source FIFO head word, valid while i_fifo_empty=0
//   o_fifo_rd     one-cycle pop strobe, high in the first START cycle
//   o_tx          serial line, idle high
//   o_busy        high whenever the FSM is not idle
//   o_tx_done     one-cycle pulse in the last stop-bit cycle
//-----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DAT_WIDTH    = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_fifo_empty,
    input  logic [DAT_WIDTH-1:0] i_fifo_data,
    output logic                 o_fifo_rd,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DAT_WIDTH > 1) ? $clog2(DAT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DAT_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DAT_WIDTH-1:0] r_shift;
    logic [DAT_WIDTH-1:0] w_shift_nxt;
    logic                 w_load;
    logic                 w_bit_end;
    logic                 w_tx_nxt;
    logic                 r_tx;
    logic                 r_fifo_rd;
    logic                 r_busy;
    logic                 r_tx_done;

    // Even parity over one data word.
    function automatic logic even_parity(input logic [DAT_WIDTH-1:0] d);
        return ^d;
    endfunction

`ifdef FIFO_UART_TX_PARITY_EN
    logic r_par;
    logic w_par_nxt;

    // Parity is captured together with the word, before any shifting.
    always_comb begin
        w_par_nxt = w_load ? even_parity(i_fifo_data) : r_par;
    end

    // Parity bit register, no reset needed (only read inside a frame).
    always_ff @(posedge clk) begin
        r_par <= w_par_nxt;
    end
`endif

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Next-state, baud counter, bit index and shift register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_fifo_empty) begin
                    w_state_nxt = ST_START;
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = i_fifo_data;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    // A waiting word chains straight into a new start bit.
                    if (!i_fifo_empty) begin
                        w_state_nxt = ST_START;
                        w_load      = 1'b1;
                        w_shift_nxt = i_fifo_data;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Serial line value for the state being entered, so o_tx is registered.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_IDLE:   w_tx_nxt = 1'b1;
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = w_par_nxt;
`endif
            ST_STOP:   w_tx_nxt = 1'b1;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tx      <= 1'b1;
            r_fifo_rd <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_fifo_rd <= w_load;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_tx_done <= (w_state_nxt == ST_STOP) && (w_cnt_nxt == CNT_LAST);
        end
    end

    // Data shift register; contents are don't-care outside a frame.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign o_tx      = r_tx;
    assign o_fifo_rd = r_fifo_rd;
    assign o_busy    = r_busy;
    assign o_tx_done = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_fifo_empty = 1'b1;
    logic [W-1:0] i_fifo_data = '0;
    logic         o_fifo_rd;
    logic         o_tx;
    logic         o_busy;
    logic         o_tx_done;

    fifo_uart_tx #(.DAT_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_rd    (o_fifo_rd),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_tx_done    (o_tx_done)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [W-1:0] q[$];
    int           m_pos = -1;      // cycle index inside current frame, -1 idle
    logic [W-1:0] m_word = '0;
    logic         tx_hist [0:16383];
    int           done_q[$];
    int           rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected line level for a given frame position, from the frame layout.
    function automatic logic exp_tx_f(input int pos, input logic [W-1:0] w);
        int b;
        if (pos < 0) return 1'b1;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= W) return w[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (b == W + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    // Reference model: advance one clock edge using the inputs seen at that edge.
    function automatic void model_edge();
        if (reset) begin
            m_pos = -1;
        end else if ((m_pos == -1 || m_pos == FRAME - 1) && !i_fifo_empty) begin
            m_pos  = 0;
            m_word = i_fifo_data;
        end else if (m_pos == FRAME - 1) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos = m_pos + 1;
        end
    endfunction

    task automatic refresh_fifo();
        i_fifo_empty = (q.size() == 0);
        i_fifo_data  = (q.size() != 0) ? q[0] : W'($urandom);
    endtask

    // One clock: model step, FIFO reaction, per-cycle compare, event logging.
    task automatic cycle();
        logic rd_pre;
        rd_pre = o_fifo_rd;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_pre && q.size() != 0) void'(q.pop_front());
        refresh_fifo();
        chk("tx", 32'(o_tx), 32'(exp_tx_f(m_pos, m_word)));
        chk("fifo_rd", 32'(o_fifo_rd), 32'(m_pos == 0));
        chk("busy", 32'(o_busy), 32'(m_pos >= 0));
        chk("tx_done", 32'(o_tx_done), 32'(m_pos == FRAME - 1));
        if (cyc < 16384) tx_hist[cyc] = o_tx;
        if (o_tx_done) done_q.push_back(cyc);
        if (o_fifo_rd) rd_q.push_back(cyc);
    endtask

    task automatic clear_logs();
        done_q.delete();
        rd_q.delete();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((m_pos >= 0 || q.size() != 0 || o_busy) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic run_until_pos(input int pos, input int budget);
        int n;
        n = 0;
        while (m_pos != pos && n < budget) begin
            cycle();
            n++;
        end
        chk("reach_pos_timeout", 32'(m_pos == pos), 32'd1);
    endtask

    function automatic logic hist(input int c);
        if (c < 0 || c > 16383) return 1'bx;
        return tx_hist[c];
    endfunction

    function automatic int qget(input int qq[$], input int i);
        if (i < qq.size()) return qq[i];
        return -1000;
    endfunction

    initial begin
        logic [10:0] a5_bits;
        int          len_lit;
        int          rst_at;
`ifdef FIFO_UART_TX_PARITY_EN
        a5_bits = 11'b10101001010;
        len_lit = 44;
`else
        a5_bits = 11'b01101001010;
        len_lit = 40;
`endif
        // Reset state
        refresh_fifo();
        repeat (3) cycle();
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_tx_done", 32'(o_tx_done), 32'd0);
        #3 reset = 1'b0;

        // Empty source for 100 cycles
        clear_logs();
        repeat (100) cycle();
        chk("empty_rd_count", 32'(rd_q.size()), 32'd0);
        chk("empty_done_count", 32'(done_q.size()), 32'd0);

        // Single word A5
        clear_logs();
        q.push_back(8'hA5);
        run_until_idle(200);
        chk("a5_rd_count", 32'(rd_q.size()), 32'd1);
        for (int b = 0; b < NBITS; b++)
            chk("a5_bit_centre", 32'(hist(qget(rd_q, 0) + b * CPB + 2)), 32'(a5_bits[b]));
        chk("a5_done_cycle", 32'(qget(done_q, 0) - qget(rd_q, 0) + 1), 32'(len_lit));
        chk("a5_busy_after", 32'(o_busy), 32'd0);

        // Back-to-back 00 then FF
        clear_logs();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        run_until_idle(300);
        chk("b2b_rd_count", 32'(rd_q.size()), 32'd2);
        chk("b2b_done_spacing", 32'(qget(done_q, 1) - qget(done_q, 0)), 32'(len_lit));
        chk("b2b_gapless_start", 32'(qget(rd_q, 1) - qget(done_q, 0)), 32'd1);
        chk("b2b_start_bit", 32'(hist(qget(done_q, 0) + 1)), 32'd0);

        // Late data: second word appears during STOP of the first frame
        clear_logs();
        q.push_back(8'h5A);
        run_until_pos(FRAME - 3, 200);
        q.push_back(8'hC3);
        run_until_idle(300);
        chk("late_rd_count", 32'(rd_q.size()), 32'd2);
        chk("late_rd_cycle", 32'(qget(rd_q, 1) - qget(done_q, 0)), 32'd1);
        chk("late_start_bit", 32'(hist(qget(done_q, 0) + 1)), 32'd0);

        // Reset during data bit 3 of 3C; 81 must then go out complete
        clear_logs();
        q.push_back(8'h3C);
        q.push_back(8'h81);
        run_until_pos(4 * CPB + 1, 200);
        #3 reset = 1'b1;
        #1;
        chk("midrst_tx", 32'(o_tx), 32'd1);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        repeat (2) cycle();
        #3 reset = 1'b0;
        clear_logs();
        run_until_idle(300);
        chk("midrst_rd_count", 32'(rd_q.size()), 32'd1);
        chk("midrst_len", 32'(qget(done_q, 0) - qget(rd_q, 0) + 1), 32'(len_lit));
        chk("midrst_81_lsb", 32'(hist(qget(rd_q, 0) + CPB + 2)), 32'd1);
        chk("midrst_81_bit1", 32'(hist(qget(rd_q, 0) + 2 * CPB + 2)), 32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity bits of 07 and 03
        clear_logs();
        q.push_back(8'h07);
        q.push_back(8'h03);
        run_until_idle(300);
        chk("par_07", 32'(hist(qget(rd_q, 0) + (W + 1) * CPB + 2)), 32'd1);
        chk("par_03", 32'(hist(qget(rd_q, 1) + (W + 1) * CPB + 2)), 32'd0);
        chk("par_len", 32'(qget(done_q, 0) - qget(rd_q, 0) + 1), 32'd44);
`endif

        // Randomized traffic with one asynchronous reset pulse
        rst_at = $urandom_range(2500, 500);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29, 0) == 0 && q.size() < 4) q.push_back(W'($urandom));
            if (i == rst_at) begin
                #($urandom_range(7, 1)) reset = 1'b1;
                #1;
                chk("rnd_rst_tx", 32'(o_tx), 32'd1);
                chk("rnd_rst_busy", 32'(o_busy), 32'd0);
                cycle();
                #3 reset = 1'b0;
            end
            cycle();
        end
        run_until_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DAT_WIDTH, 8: data word width in bits.
REQ-002 Parameter CLKS_PER_BIT, 434: clk cycles per serial bit; legal range is 2 or more.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  source FIFO empty flag, registered in the FIFO.
REQ-006 fifo_data  input  DAT_WIDTH  source FIFO head word, first-word-fall-through, valid whenever fifo_empty=0.
REQ-007 fifo_rd  output  DAT_WIDTH-independent 1  registered pop strobe to the FIFO.
REQ-008 tx  output  1  registered serial line, idle high.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 tx_done  output  1  registered one-cycle pulse at the end of each frame.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-025.
- IDLE: tx=1.
- IDLE -> START on a clk edge with fifo_empty=0.
REQ-012 On the IDLE->START edge the block SHALL:
- latch fifo_data into the shift register;
- set fifo_rd=1 for exactly the first START cycle;
- drive tx=0.
REQ-013 fifo_rd SHALL never be high for more than one cycle per word and SHALL never be high while fifo_empty was 1 on the deciding edge.
REQ-014 Each bit (start, data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at each bit boundary.
REQ-015 DATA SHALL shift out DAT_WIDTH bits LSB first, using a bit index counter of width clog2(DAT_WIDTH).
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-017 In the last STOP cycle tx_done SHALL be 1.
REQ-018 Back-to-back frames:
- If fifo_empty=0 on the final STOP edge, the FSM SHALL go directly STOP->START with the REQ-012 actions, giving no idle gap between frames.
- Otherwise the FSM SHALL go to IDLE.
REQ-019 fifo_empty changing during a frame SHALL have no effect on that frame.
REQ-020 The frame length SHALL be (DAT_WIDTH+2)*CLKS_PER_BIT cycles, measured from tx falling to the end of STOP.

Reset
REQ-021 While reset=1 the outputs SHALL be tx=1, fifo_rd=0, busy=0 and tx_done=0, and the FSM SHALL be in IDLE with counters cleared.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously); the popped word is discarded.
REQ-023 After reset deasserts, the first frame SHALL start on the first clk edge with fifo_empty=0.
REQ-024 The shift register need not be reset.

Configuration
REQ-025 With macro FIFO_UART_TX_PARITY_EN defined:
- a PARITY state SHALL follow DATA, lasting CLKS_PER_BIT cycles;
- tx SHALL equal the XOR of the DAT_WIDTH data bits (even parity);
- frame length SHALL be (DAT_WIDTH+3)*CLKS_PER_BIT.
REQ-026 Without FIFO_UART_TX_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL be synthesized.

Verification (DAT_WIDTH=8, CLKS_PER_BIT=4)
REQ-027 Single word:
- Stimulus: FIFO holds 8'hA5.
- Required response: fifo_rd pulses once; tx samples at bit centres read 0,1,0,1,0,0,1,0,1,1; tx_done pulses at cycle 40 after tx falls; busy drops afterwards.
REQ-028 Back-to-back:
- Stimulus: FIFO holds 8'h00 then 8'hFF.
- Required response: the second start bit begins on the cycle right after the first frame's last stop cycle; exactly two fifo_rd pulses; tx_done pulses 40 cycles apart.
REQ-029 Empty source:
- Stimulus: fifo_empty held at 1 for 100 cycles.
- Required response: tx=1, fifo_rd=0 and busy=0 throughout.
REQ-030 Reset mid-frame:
- Stimulus: reset asserted during data bit 3 of 8'h3C.
- Required response: tx=1 and busy=0 immediately; after release, the next queued word 8'h81 transmits as a complete frame.
REQ-031 Parity build:
- Stimulus: FIFO_UART_TX_PARITY_EN defined; send 8'h07, then 8'h03.
- Required response: the parity bit is 1 for 8'h07 and 0 for 8'h03; the frame is 44 cycles.
REQ-032 Late data:
- Stimulus: fifo_empty falls during STOP of the previous frame.
- Required response: the next frame starts gaplessly at the end of STOP; no fifo_rd is issued before that edge.
